inst_fetch: RTL

//   Instruction fetch/issue unit for the 4-bit CPU. It is the producer side of the D0..D3 opcode bus that the

---
 rtl/cpu4_pkg.sv | 44 ++++
 rtl/inst_fetch.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit CPU: opcode map, fetch-unit state encoding
// and the operand-length helper used by the fetch unit.
package cpu4_pkg;

    localparam logic [3:0] OP_LD   = 4'h0;
    localparam logic [3:0] OP_STR  = 4'h1;
    localparam logic [3:0] OP_SEI  = 4'h2;
    localparam logic [3:0] OP_SML  = 4'h3;
    localparam logic [3:0] OP_JMP0 = 4'h4;
    localparam logic [3:0] OP_JMP1 = 4'h5;
    localparam logic [3:0] OP_JMP2 = 4'h6;
    localparam logic [3:0] OP_LDD  = 4'h7;
    localparam logic [3:0] OP_ARI0 = 4'h8;
    localparam logic [3:0] OP_ARI1 = 4'h9;
    localparam logic [3:0] OP_ARI2 = 4'hA;
    localparam logic [3:0] OP_ARI3 = 4'hB;
    localparam logic [3:0] OP_LOG0 = 4'hC;
    localparam logic [3:0] OP_LOG1 = 4'hD;
    localparam logic [3:0] OP_LOG2 = 4'hE;
    localparam logic [3:0] OP_SMH  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_OP  = 3'd1,
        ST_FETCH_IMM = 3'd2,
        ST_FETCH_ADR = 3'd3,
        ST_ISSUE     = 3'd4
    } fetchState_t;

    function automatic logic isJmp(input logic [3:0] op);
        return (op == OP_JMP0) || (op == OP_JMP1) || (op == OP_JMP2);
    endfunction

    // Number of operand nibbles that follow the opcode nibble in program memory.
    function automatic int unsigned opr_nibbles(input logic [3:0] op, input int unsigned addrNib);
        if (op == OP_LDD)
            return 1;
        else if (isJmp(op))
            return addrNib;
        else
            return 0;
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch/issue unit: walks the PC over a req/ack nibble memory,
// assembles operands and issues one instruction at a time on a valid/ready port.
module inst_fetch
    import cpu4_pkg::*;
#(
    parameter int unsigned             ADDR_NIB = 2,
    parameter logic [4*ADDR_NIB-1:0]   RST_PC   = '0
) (
    input  logic                  CLK1,
    input  logic                  RST_C,
    input  logic                  RUN,
    input  logic                  FLUSH,
    input  logic [4*ADDR_NIB-1:0] FLUSH_PC,
    output logic                  MEM_REQ,
    output logic [4*ADDR_NIB-1:0] MEM_ADDR,
    input  logic                  MEM_ACK,
    input  logic [3:0]            MEM_DATA,
    output logic                  D0,
    output logic                  D1,
    output logic                  D2,
    output logic                  D3,
    output logic [4*ADDR_NIB-1:0] OPR,
    output logic                  OP_V,
    input  logic                  OP_RDY,
    output logic                  BUSY
);

    localparam int unsigned PC_W  = 4 * ADDR_NIB;
    localparam int unsigned CNT_W = (ADDR_NIB > 1) ? $clog2(ADDR_NIB) : 1;

    fetchState_t      state;
    fetchState_t      nextState;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  opr;
    logic [3:0]       opcode;
    logic [CNT_W-1:0] nibCnt;
    logic             flushPend;
    logic [PC_W-1:0]  flushTgt;

    logic             inFetch;
    logic             xfer;
    logic             goodAck;
    logic             redirect;
    logic             lastAdr;
    logic [PC_W-1:0]  redirectTgt;

    assign inFetch = (state == ST_FETCH_OP) || (state == ST_FETCH_IMM) || (state == ST_FETCH_ADR);
    assign xfer    = (state == ST_ISSUE) && OP_RDY;
    assign lastAdr = (nibCnt == CNT_W'(ADDR_NIB - 1));

    // A request is never withdrawn: a flush seen mid-request waits for the ack and drops its data.
    assign goodAck     = inFetch && MEM_ACK && !FLUSH && !flushPend;
    assign redirect    = (FLUSH && !inFetch) || (inFetch && MEM_ACK && (FLUSH || flushPend));
    assign redirectTgt = FLUSH ? FLUSH_PC : flushTgt;

    always_ff @(posedge CLK1 or negedge RST_C) begin
        if (!RST_C)
            state <= ST_IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (RUN)
                    nextState = ST_FETCH_OP;
            end
            ST_FETCH_OP: begin
                if (goodAck) begin
                    if (opr_nibbles(MEM_DATA, ADDR_NIB) == 0)
                        nextState = ST_ISSUE;
                    else if (MEM_DATA == OP_LDD)
                        nextState = ST_FETCH_IMM;
                    else
                        nextState = ST_FETCH_ADR;
                end
            end
            ST_FETCH_IMM: begin
                if (goodAck)
                    nextState = ST_ISSUE;
            end
            ST_FETCH_ADR: begin
                if (goodAck && lastAdr)
                    nextState = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (xfer)
                    nextState = RUN ? ST_FETCH_OP : ST_IDLE;
            end
            default: nextState = ST_IDLE;
        endcase
        if (redirect)
            nextState = RUN ? ST_FETCH_OP : ST_IDLE;
    end

    always_comb begin
        MEM_REQ = inFetch;
        OP_V    = (state == ST_ISSUE);
        BUSY    = (state != ST_IDLE);
    end

    assign MEM_ADDR = pc;
    assign OPR      = opr;
    assign {D3, D2, D1, D0} = opcode;

    // PC, flush bookkeeping and operand assembly.
    always_ff @(posedge CLK1 or negedge RST_C) begin
        if (!RST_C) begin
            pc        <= RST_PC;
            opcode    <= '0;
            opr       <= '0;
            nibCnt    <= '0;
            flushPend <= 1'b0;
            flushTgt  <= '0;
        end else begin
            if (redirect) begin
                pc        <= redirectTgt;
                flushPend <= 1'b0;
            end else begin
                if (FLUSH) begin
                    flushPend <= 1'b1;
                    flushTgt  <= FLUSH_PC;
                end
                if (goodAck)
                    pc <= pc + PC_W'(1);
                else if (xfer && isJmp(opcode))
                    pc <= opr;
            end

            if (goodAck) begin
                case (state)
                    ST_FETCH_OP: begin
                        opcode <= MEM_DATA;
                        opr    <= '0;
                        nibCnt <= '0;
                    end
                    ST_FETCH_IMM: opr <= PC_W'(MEM_DATA);
                    ST_FETCH_ADR: begin
                        opr[4*nibCnt +: 4] <= MEM_DATA;
                        nibCnt             <= nibCnt + CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
